// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC / instruction-fetch sequencer.
//   fetch_state_e   : sequencer states (3-bit encoding)
//   DefaultResetPc  : default architectural reset PC
//   NopInstr        : canonical NOP (addi x0, x0, 0)
//   is_aligned()    : true when a PC is on a 4-byte boundary
package pc_fetch_unit_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StWait  = 3'd2,
    StHold  = 3'd3,
    StDrain = 3'd4,
    StHalt  = 3'd5
  } fetch_state_e;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
  localparam logic [31:0] NopInstr       = 32'h0000_0013;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// Program-counter register and single-outstanding instruction-fetch sequencer.
// Holds the PC, feeds it to the external PC+4 incrementer, fetches one word at a
// time over a req/gnt/rvalid port and presents it to decode with a valid/ready
// handshake. Redirects (branch/jump) take priority over stall and ready.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   pc_o / pc_plus4_i                 current PC out, incremented PC back
//   redirect_i / redirect_target_i    branch/jump pulse and its target
//   stall_i                           blocks the HOLD -> REQ advance only
//   imem_req_o / imem_addr_o          fetch request and address (= pc_o)
//   imem_gnt_i / imem_rvalid_i        request accepted / read data valid
//   imem_rdata_i                      fetched instruction word
//   instr_valid_o / instr_ready_i     decode handshake
//   instr_o / instr_pc_o              presented instruction and its PC
//   misalign_o                        sticky misaligned-redirect flag
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  input  logic [31:0] pc_plus4_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        misalign_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         misalign_q, misalign_d;
  logic         imem_req_q;
  logic         instr_valid_q;
  logic         redir_ok;
  logic         redir_bad;

  assign redir_ok  = redirect_i & is_aligned(redirect_target_i);
  assign redir_bad = redirect_i & ~is_aligned(redirect_target_i);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    misalign_d = misalign_q;

    if (redir_ok) begin
      pc_d       = redirect_target_i;
      misalign_d = 1'b0;
    end else if (redir_bad) begin
      misalign_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        state_d = redir_bad ? StHalt : StReq;
      end
      StReq: begin
        if (redirect_i) begin
          // A granted request has an rvalid coming that must be swallowed.
          if (imem_gnt_i)    state_d = StDrain;
          else if (redir_ok) state_d = StReq;
          else               state_d = StHalt;
        end else if (imem_gnt_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_i) begin
          // If the response lands in the redirect cycle it is already gone.
          if (!imem_rvalid_i) state_d = StDrain;
          else if (redir_ok)  state_d = StReq;
          else                state_d = StHalt;
        end else if (imem_rvalid_i) begin
          instr_d    = imem_rdata_i;
          instr_pc_d = pc_q;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (redirect_i) begin
          state_d = redir_ok ? StReq : StHalt;
        end else if (instr_ready_i && !stall_i) begin
          pc_d    = pc_plus4_i;
          state_d = StReq;
        end
      end
      StDrain: begin
        // misalign_d folds in a redirect arriving during the drain itself.
        if (imem_rvalid_i) state_d = misalign_d ? StHalt : StReq;
      end
      StHalt: begin
        if (redir_ok) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      misalign_q    <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      misalign_q    <= misalign_d;
      imem_req_q    <= (state_d == StReq);
      instr_valid_q <= (state_d == StHold);
    end
  end

  assign pc_o          = pc_q;
  assign imem_addr_o   = pc_q;
  assign imem_req_o    = imem_req_q;
  assign instr_valid_o = instr_valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign misalign_o    = misalign_q;

endmodule
